// File: rtl/counter_seq_pkg.sv
// Shared types and register-map constants for the counter sequencer.
package counter_seq_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_e;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_LEN    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_TABLE  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_VALUE  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_EXPCNT = 3'd5;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_STOP  = 1;
    localparam int unsigned CTRL_LOOP  = 2;
    localparam int unsigned CTRL_CLRW  = 3;

endpackage

// File: rtl/counter_seq_table.sv
// DEPTH x CFG_W config table: synchronous write, combinational read.
module counter_seq_table #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CFG_W = 2,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CFG_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [CFG_W-1:0] rdata
);

    logic [CFG_W-1:0] mem [DEPTH];

    // Table storage, cleared on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/counter_seq_controller.sv
// Avalon-MM sequencer stepping custom_counter_unit through a table of
// load_config values. Optional expiry counter: COUNTER_SEQ_EXPCNT_EN.
module counter_seq_controller
    import counter_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CFG_W = 2,
    parameter int unsigned CNT_W = 27
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] writedata,
    output logic              seq_done_irq,
    output logic              reset_counter,
    output logic              load,
    output logic [CFG_W-1:0]  load_config,
    input  logic [CNT_W-1:0]  counter_value,
    input  logic              counter_expire
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = IDX_W + 1;

    seq_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  wptr_q;
    logic [LEN_W-1:0]  len_q;
    logic              loop_q;
    logic              exp_q;
    logic [DATA_W-1:0] expcnt;

    logic              wr_c, rd_c, ctrl_wr, start_req, stop_req;
    logic              busy, exp_edge, last, done_set, irq_clr;
    logic              len_wr_ok, tbl_we;
    logic [IDX_W-1:0]  nxt_idx, tbl_raddr;
    logic [CFG_W-1:0]  tbl_rdata;

    // Bus decode and sequencing conditions.
    always_comb begin
        wr_c      = chipselect & write;
        rd_c      = chipselect & read;
        busy      = (state_q != IDLE);
        ctrl_wr   = wr_c && (address == ADDR_CTRL);
        start_req = ctrl_wr && writedata[CTRL_START];
        stop_req  = ctrl_wr && writedata[CTRL_STOP];
        irq_clr   = wr_c && (address == ADDR_IRQ);
        len_wr_ok = wr_c && (address == ADDR_LEN) && !busy &&
                    (writedata != '0) && (writedata <= DATA_W'(DEPTH));
        tbl_we    = wr_c && (address == ADDR_TABLE) && !busy;
        exp_edge  = counter_expire & ~exp_q;
        last      = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
        nxt_idx   = last ? '0 : (idx_q + IDX_W'(1));
        tbl_raddr = (state_q == RUN) ? nxt_idx : '0;
        done_set  = (state_q == RUN) && exp_edge && last && !loop_q && !stop_req;
    end

    counter_seq_table #(
        .DEPTH (DEPTH),
        .CFG_W (CFG_W)
    ) u_table (
        .clock  (clock),
        .resetn (resetn),
        .we     (tbl_we),
        .waddr  (wptr_q),
        .wdata  (writedata[CFG_W-1:0]),
        .raddr  (tbl_raddr),
        .rdata  (tbl_rdata)
    );

    // Sequencer FSM with registered counter-unit controls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            load          <= 1'b0;
            load_config   <= '0;
            reset_counter <= 1'b1;
        end else begin
            load <= 1'b0;
            if (stop_req) begin
                state_q       <= IDLE;
                reset_counter <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        reset_counter <= 1'b1;
                        if (start_req) begin
                            state_q     <= LOAD;
                            idx_q       <= '0;
                            load        <= 1'b1;
                            load_config <= tbl_rdata;
                        end
                    end
                    LOAD: begin
                        state_q       <= RUN;
                        reset_counter <= 1'b0;
                    end
                    RUN: begin
                        reset_counter <= 1'b0;
                        if (exp_edge) begin
                            if (!last || loop_q) begin
                                state_q       <= LOAD;
                                idx_q         <= nxt_idx;
                                load          <= 1'b1;
                                load_config   <= tbl_rdata;
                                reset_counter <= 1'b1;
                            end else begin
                                state_q       <= IDLE;
                                reset_counter <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q       <= IDLE;
                        reset_counter <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Done interrupt; a same-cycle set beats a software clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seq_done_irq <= 1'b0;
        end else if (done_set) begin
            seq_done_irq <= 1'b1;
        end else if (irq_clr) begin
            seq_done_irq <= 1'b0;
        end
    end

    // Control registers: expiry history, loop flag, length, write pointer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp_q  <= 1'b0;
            loop_q <= 1'b0;
            len_q  <= LEN_W'(1);
            wptr_q <= '0;
        end else begin
            exp_q <= counter_expire;
            if (ctrl_wr) begin
                loop_q <= writedata[CTRL_LOOP];
                if (writedata[CTRL_CLRW]) begin
                    wptr_q <= '0;
                end
            end
            if (len_wr_ok) begin
                len_q <= LEN_W'(writedata);
            end
            if (tbl_we) begin
                wptr_q <= wptr_q + IDX_W'(1);
            end
        end
    end

`ifdef COUNTER_SEQ_EXPCNT_EN
    // Expiry counter: counts expiries seen in RUN, cleared by an accepted start.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            expcnt <= '0;
        end else if (start_req && !stop_req && !busy) begin
            expcnt <= '0;
        end else if ((state_q == RUN) && exp_edge) begin
            expcnt <= expcnt + DATA_W'(1);
        end
    end
`else
    assign expcnt = '0;
`endif

    // Registered read data, one-cycle latency.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            readdata <= '0;
        end else if (rd_c) begin
            case (address)
                ADDR_CTRL:   readdata <= DATA_W'({busy, loop_q, idx_q});
                ADDR_LEN:    readdata <= DATA_W'(len_q);
                ADDR_IRQ:    readdata <= DATA_W'(seq_done_irq);
                ADDR_TABLE:  readdata <= DATA_W'(wptr_q);
                ADDR_VALUE:  readdata <= DATA_W'(counter_value);
                ADDR_EXPCNT: readdata <= expcnt;
                default:     readdata <= '0;
            endcase
        end
    end

endmodule
